// File: rtl/vga_mem_pxl_writer_if.sv
// ---------------------------------------------------------------------------
// vga_mem_pxl_writer_if.sv
// Bus bundles used by the VGA frame-buffer pixel writer.
//
// vga_pxl_stream_if : framed pixel stream, valid/ready handshake
//   valid  source -> sink   pixel valid
//   ready  sink -> source   sink can accept a pixel
//   data   source -> sink   pixel value (PXL_WIDTH bits)
//   sof    source -> sink   first pixel of a frame (qualified by valid)
//   master = pixel source, slave = pixel sink (the writer)
//
// vga_mem_wr_if : BRAM write port
//   addr   word address (MEM_ADDR_WIDTH bits)
//   din    write data (MEM_WIDTH bits)
//   we     write enable, one-cycle pulse
//   en     port enable, mirrors we
//   master = writer, slave = BRAM
// ---------------------------------------------------------------------------
interface vga_pxl_stream_if #(
  parameter int PXL_WIDTH = 1
);
  logic                 valid;
  logic                 ready;
  logic                 sof;
  logic [PXL_WIDTH-1:0] data;

  modport master (output valid, data, sof, input ready);
  modport slave  (input valid, data, sof, output ready);
endinterface

interface vga_mem_wr_if #(
  parameter int MEM_ADDR_WIDTH = 16,
  parameter int MEM_WIDTH      = 8
);
  logic [MEM_ADDR_WIDTH-1:0] addr;
  logic [MEM_WIDTH-1:0]      din;
  logic                      we;
  logic                      en;

  modport master (output addr, din, we, en);
  modport slave  (input addr, din, we, en);
endinterface

// File: rtl/vga_mem_pxl_writer.sv
// ---------------------------------------------------------------------------
// vga_mem_pxl_writer.sv
// Write-side front end of the VGA frame buffer. Packs PXL_PER_ROW pixels of
// an incoming framed pixel stream into one memory word (first pixel in the
// LSBs) and writes each completed word to the BRAM write port. Tracks frame
// alignment, wraps the word address at end of frame, and flags frame
// completion and start-of-frame misalignment.
//
// Ports:
//   clk_i         pixel-domain clock
//   rst_i         synchronous reset, active high
//   en_i          writer enable; low drops back to IDLE
//   pxl           pixel stream sink (valid/ready/data/sof)
//   mem           BRAM write port (addr/din/we/en), registered
//   frame_done_o  one-cycle pulse with the write of the last frame word
//   sync_err_o    one-cycle pulse when SOF arrives mid-frame
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for SOF; pixels without SOF are accepted and dropped
// FILL  | in a frame; packing pixels, writing a word every PXL_PER_ROW
// ---------------------------------------------------------------------------
module vga_mem_pxl_writer #(
  parameter int PXL_WIDTH      = 1,
  parameter int PXL_PER_ROW    = 8,
  parameter int MEM_DEPTH      = 38400,
  parameter int MEM_ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    en_i,
  vga_pxl_stream_if.slave         pxl,
  vga_mem_wr_if.master            mem,
  output logic                    frame_done_o,
  output logic                    sync_err_o
);

  localparam int MEM_WIDTH = PXL_PER_ROW * PXL_WIDTH;
  localparam int IDX_W     = (PXL_PER_ROW > 1) ? $clog2(PXL_PER_ROW) : 1;

  localparam logic [IDX_W-1:0]          LAST_IDX  = IDX_W'(PXL_PER_ROW - 1);
  localparam logic [MEM_ADDR_WIDTH-1:0] LAST_ADDR = MEM_ADDR_WIDTH'(MEM_DEPTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  state_t                    state_q, state_d;
  logic [MEM_WIDTH-1:0]      pack_q, pack_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [MEM_ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [MEM_WIDTH-1:0]      din_q, din_d;
  logic                      we_q, we_d;
  logic                      done_q, done_d;
  logic                      err_q, err_d;

  logic                      xfer;
  logic [MEM_WIDTH-1:0]      word_v;   // pack register with this pixel merged in
  logic [MEM_WIDTH-1:0]      first_v;  // fresh word holding only this pixel

  assign pxl.ready    = en_i && !rst_i;
  assign xfer         = pxl.valid && pxl.ready;

  assign mem.addr     = addr_q;
  assign mem.din      = din_q;
  assign mem.we       = we_q;
  assign mem.en       = we_q;
  assign frame_done_o = done_q;
  assign sync_err_o   = err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      pack_q  <= '0;
      idx_q   <= '0;
      waddr_q <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pack_q  <= pack_d;
      idx_q   <= idx_d;
      waddr_q <= waddr_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      we_q    <= we_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pack_d  = pack_q;
    idx_d   = idx_q;
    waddr_d = waddr_q;
    addr_d  = addr_q;
    din_d   = din_q;
    we_d    = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;

    word_v = pack_q;
    word_v[int'(idx_q)*PXL_WIDTH +: PXL_WIDTH] = pxl.data;
    first_v = '0;
    first_v[PXL_WIDTH-1:0] = pxl.data;

    if (!en_i) begin
      // Disable abandons the partial word silently; an already registered
      // write strobe is unaffected since it lives in we_q.
      state_d = IDLE;
      pack_d  = '0;
      idx_d   = '0;
      waddr_d = '0;
    end else if (xfer) begin
      case (state_q)
        IDLE: begin
          if (pxl.sof) begin
            state_d = FILL;
            pack_d  = first_v;
            idx_d   = IDX_W'(1);
            waddr_d = '0;
          end
        end
        FILL: begin
          // SOF is only legal exactly on a frame boundary; anywhere else it
          // resynchronises: drop the partial word, restart at address 0.
          if (pxl.sof && (idx_q != '0 || waddr_q != '0)) begin
            err_d   = 1'b1;
            pack_d  = first_v;
            idx_d   = IDX_W'(1);
            waddr_d = '0;
          end else if (idx_q == LAST_IDX) begin
            we_d   = 1'b1;
            din_d  = word_v;
            addr_d = waddr_q;
            pack_d = '0;
            idx_d  = '0;
            if (waddr_q == LAST_ADDR) begin
              waddr_d = '0;
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              waddr_d = waddr_q + 1'b1;
            end
          end else begin
            pack_d = word_v;
            idx_d  = idx_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_mem_pxl_writer.sv
module tb_vga_mem_pxl_writer;

  localparam int PW    = 1;
  localparam int PPR   = 8;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int MW    = PPR * PW;

  logic clk_i = 1'b0;
  logic rst_i;
  logic en_i;
  logic frame_done_o;
  logic sync_err_o;

  always #5 clk_i = ~clk_i;

  vga_pxl_stream_if #(.PXL_WIDTH(PW)) pxl_if ();
  vga_mem_wr_if #(.MEM_ADDR_WIDTH(AW), .MEM_WIDTH(MW)) mem_if ();

  vga_mem_pxl_writer #(
    .PXL_WIDTH      (PW),
    .PXL_PER_ROW    (PPR),
    .MEM_DEPTH      (DEPTH),
    .MEM_ADDR_WIDTH (AW)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .en_i         (en_i),
    .pxl          (pxl_if),
    .mem          (mem_if),
    .frame_done_o (frame_done_o),
    .sync_err_o   (sync_err_o)
  );

  int tests = 0;
  int fails = 0;

  // write log captured away from the active edge
  logic [AW-1:0] wa_q[$];
  logic [MW-1:0] wd_q[$];
  logic          wdone_q[$];
  int            serr_cnt = 0;
  int            done_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (mem_if.we === 1'b1) begin
      wa_q.push_back(mem_if.addr);
      wd_q.push_back(mem_if.din);
      wdone_q.push_back(frame_done_o);
      chk("mem_en_follows_we", {31'd0, mem_if.en}, 32'd1);
    end
    if (sync_err_o === 1'b1) serr_cnt++;
    if (frame_done_o === 1'b1) done_cnt++;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic send_px(input logic d, input logic sof);
    pxl_if.valid = 1'b1;
    pxl_if.data  = d;
    pxl_if.sof   = sof;
    @(posedge clk_i);
    #1;
    pxl_if.valid = 1'b0;
    pxl_if.sof   = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w, input logic sof_first, input int max_gap);
    for (int k = 0; k < 8; k++) begin
      send_px(w[k], sof_first && (k == 0));
      if (max_gap > 0 && k < 7) idle($urandom_range(0, max_gap));
    end
  endtask

  task automatic reset_dut();
    rst_i = 1'b1;
    idle(2);
    rst_i = 1'b0;
  endtask

  int base, sbase, dbase;
  logic [7:0] w;
  logic [7:0] frame_a [4];
  logic [7:0] frame_b [4];

  initial begin
    frame_a = '{8'h4D, 8'hA5, 8'h3C, 8'hFF};
    frame_b = '{8'hE5, 8'hF6, 8'h07, 8'h18};

    // ---- reset with pixels offered ----
    rst_i = 1'b1;
    en_i  = 1'b1;
    pxl_if.valid = 1'b1;
    pxl_if.sof   = 1'b1;
    pxl_if.data  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_i);
      #1;
      chk("ready_low_in_reset", {31'd0, pxl_if.ready}, 32'd0);
    end
    chk("rst_we",    {31'd0, mem_if.we}, 32'd0);
    chk("rst_en",    {31'd0, mem_if.en}, 32'd0);
    chk("rst_addr",  {30'd0, mem_if.addr}, 32'd0);
    chk("rst_din",   {24'd0, mem_if.din}, 32'd0);
    chk("rst_done",  {31'd0, frame_done_o}, 32'd0);
    chk("rst_serr",  {31'd0, sync_err_o}, 32'd0);
    chk("rst_no_wr", wa_q.size(), 32'd0);
    pxl_if.valid = 1'b0;
    pxl_if.sof   = 1'b0;
    rst_i = 1'b0;
    #1;
    chk("ready_after_rst", {31'd0, pxl_if.ready}, 32'd1);

    // ---- packing, wrap and frame done ----
    send_word(8'h4D, 1'b1, 0);
    chk("pack_we_n1",  {31'd0, mem_if.we}, 32'd1);
    chk("pack_addr0",  {30'd0, mem_if.addr}, 32'd0);
    chk("pack_din",    {24'd0, mem_if.din}, 32'h4D);
    chk("pack_nodone", {31'd0, frame_done_o}, 32'd0);
    idle(1);
    chk("we_one_cycle", {31'd0, mem_if.we}, 32'd0);
    chk("din_holds",    {24'd0, mem_if.din}, 32'h4D);
    send_word(8'hA5, 1'b0, 0);
    chk("w1_addr", {30'd0, mem_if.addr}, 32'd1);
    chk("w1_din",  {24'd0, mem_if.din}, 32'hA5);
    send_word(8'h3C, 1'b0, 0);
    chk("w2_addr", {30'd0, mem_if.addr}, 32'd2);
    send_word(8'hFF, 1'b0, 0);
    chk("w3_we",   {31'd0, mem_if.we}, 32'd1);
    chk("w3_addr", {30'd0, mem_if.addr}, 32'd3);
    chk("w3_done", {31'd0, frame_done_o}, 32'd1);
    idle(1);
    chk("done_one_cycle", {31'd0, frame_done_o}, 32'd0);
    send_word(8'h0F, 1'b0, 0);
    idle(2);
    chk("idle_no_write", wa_q.size(), 32'd4);
    chk("no_serr_yet",   serr_cnt, 32'd0);

    // ---- mid-frame SOF ----
    base  = wa_q.size();
    sbase = serr_cnt;
    send_word(8'h11, 1'b1, 0);
    send_word(8'h22, 1'b0, 0);
    send_px(1'b1, 1'b0);
    send_px(1'b1, 1'b0);
    send_px(1'b1, 1'b0);
    w = 8'h5B;
    send_px(w[0], 1'b1);
    chk("midsof_serr",  {31'd0, sync_err_o}, 32'd1);
    chk("midsof_no_we", {31'd0, mem_if.we}, 32'd0);
    for (int k = 1; k < 8; k++) send_px(w[k], 1'b0);
    chk("resync_addr", {30'd0, mem_if.addr}, 32'd0);
    chk("resync_din",  {24'd0, mem_if.din}, 32'h5B);
    idle(2);
    chk("midsof_writes", wa_q.size(), base + 3);
    chk("midsof_serr_cnt", serr_cnt, sbase + 1);
    chk("midsof_w0_addr", {30'd0, wa_q[base]},   32'd0);
    chk("midsof_w1_addr", {30'd0, wa_q[base+1]}, 32'd1);
    chk("midsof_w1_din",  {24'd0, wd_q[base+1]}, 32'h22);

    // ---- gaps give identical words ----
    reset_dut();
    base = wa_q.size();
    for (int i = 0; i < 4; i++) send_word(frame_a[i], i == 0, 2);
    idle(2);
    chk("gap_writes", wa_q.size(), base + 4);
    for (int i = 0; i < 4; i++) begin
      chk("gap_addr", {30'd0, wa_q[base+i]}, i);
      chk("gap_din",  {24'd0, wd_q[base+i]}, {24'd0, frame_a[i]});
      chk("gap_done", {31'd0, wdone_q[base+i]}, (i == 3) ? 32'd1 : 32'd0);
    end

    // ---- enable drop mid-word ----
    base  = wa_q.size();
    sbase = serr_cnt;
    send_word(8'h4D, 1'b1, 0);
    send_px(1'b1, 1'b0);
    send_px(1'b0, 1'b0);
    send_px(1'b1, 1'b0);
    send_px(1'b0, 1'b0);
    send_px(1'b1, 1'b0);
    en_i = 1'b0;
    pxl_if.valid = 1'b1;
    pxl_if.data  = 1'b1;
    #1;
    chk("ready_low_when_dis", {31'd0, pxl_if.ready}, 32'd0);
    idle(3);
    pxl_if.valid = 1'b0;
    en_i = 1'b1;
    send_word(8'hFF, 1'b0, 0);   // no SOF: discarded in IDLE
    idle(2);
    chk("dis_no_partial_write", wa_q.size(), base + 1);
    send_word(8'h96, 1'b1, 0);
    chk("recover_we",   {31'd0, mem_if.we}, 32'd1);
    chk("recover_addr", {30'd0, mem_if.addr}, 32'd0);
    chk("recover_din",  {24'd0, mem_if.din}, 32'h96);
    idle(2);
    chk("dis_no_serr", serr_cnt, sbase);

    // ---- back-to-back frames ----
    reset_dut();
    base  = wa_q.size();
    sbase = serr_cnt;
    dbase = done_cnt;
    for (int i = 0; i < 4; i++) send_word(frame_a[i], i == 0, 0);
    for (int i = 0; i < 4; i++) send_word(frame_b[i], i == 0, 0);
    idle(2);
    chk("b2b_writes", wa_q.size(), base + 8);
    for (int i = 0; i < 8; i++) begin
      chk("b2b_addr", {30'd0, wa_q[base+i]}, i % 4);
      chk("b2b_din",  {24'd0, wd_q[base+i]}, (i < 4) ? {24'd0, frame_a[i]} : {24'd0, frame_b[i-4]});
    end
    chk("b2b_done_a", {31'd0, wdone_q[base+3]}, 32'd1);
    chk("b2b_done_b", {31'd0, wdone_q[base+7]}, 32'd1);
    chk("b2b_done_cnt", done_cnt, dbase + 2);
    chk("b2b_no_serr", serr_cnt, sbase);

    // ---- SOF on the final pixel itself is a mid-frame error ----
    base  = wa_q.size();
    sbase = serr_cnt;
    dbase = done_cnt;
    send_word(8'h11, 1'b1, 0);
    send_word(8'h22, 1'b0, 0);
    send_word(8'h33, 1'b0, 0);
    w = 8'h44;
    for (int k = 0; k < 7; k++) send_px(w[k], 1'b0);
    send_px(1'b1, 1'b1);
    chk("lastsof_serr",   {31'd0, sync_err_o}, 32'd1);
    chk("lastsof_no_we",  {31'd0, mem_if.we}, 32'd0);
    chk("lastsof_nodone", {31'd0, frame_done_o}, 32'd0);
    w = 8'h81;
    for (int k = 1; k < 8; k++) send_px(w[k], 1'b0);
    chk("lastsof_addr", {30'd0, mem_if.addr}, 32'd0);
    chk("lastsof_din",  {24'd0, mem_if.din}, 32'h81);
    idle(2);
    chk("lastsof_writes", wa_q.size(), base + 4);
    chk("lastsof_done_cnt", done_cnt, dbase);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
